// File: rtl/serial_tx_buffered_pkg.sv
// Shared definitions for the buffered 8N1 serial transmitter:
// FSM state encoding, frame length and bit-period computation.
package serial_tx_buffered_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int FRAME_BITS = 10;

  // Clocks per bit, rounded to the nearest integer.
  function automatic int calc_bit_cycles(input int clk_frequency, input int baud);
    return (clk_frequency + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/serial_tx_buffered_if.sv
// Byte-wide valid/ready handshake from a producer into the transmitter.
interface serial_tx_buffered_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/serial_tx_buffered_fifo.sv
// Synchronous first-in first-out buffer with occupancy count.
// A push is refused while full, even when a pop happens in the same cycle.
module serial_tx_fifo #(
  parameter int Width     = 8,
  parameter int DepthLog2 = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [Width-1:0]   push_data,
  input  logic               pop,
  output logic [Width-1:0]   pop_data,
  output logic               full,
  output logic               empty,
  output logic [DepthLog2:0] count
);

  logic [Width-1:0]     mem [2**DepthLog2];
  logic [DepthLog2-1:0] wr_ptr;
  logic [DepthLog2-1:0] rd_ptr;
  logic                 push_ok;
  logic                 pop_ok;

  assign full     = (count == (DepthLog2 + 1)'(2**DepthLog2));
  assign empty    = (count == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/serial_tx_buffered.sv
// Buffered 8N1 transmitter: queues handshaked bytes in a FIFO and shifts
// them out LSB first with start/stop framing, back-to-back when queued.
module serial_tx_buffered
  import serial_tx_buffered_pkg::*;
#(
  parameter int ClkFrequency  = 24000000,
  parameter int Baud          = 115200,
  parameter int FifoDepthLog2 = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_tx_buffered_if.slave    tx,
  output logic                   TxD,
  output logic                   busy,
  output logic [FifoDepthLog2:0] fifo_count
);

  localparam int BitCycles = calc_bit_cycles(ClkFrequency, Baud);
  localparam int CntWidth  = (BitCycles < 2) ? 1 : $clog2(BitCycles);

  if (BitCycles < 2) begin : g_bad_rate
    $error("serial_tx_buffered: clock too slow for the requested baud rate");
  end

  tx_state_t           state;
  tx_state_t           next_state;
  logic [CntWidth-1:0] bit_cnt;
  logic [2:0]          bit_idx;
  logic [7:0]          shift;
  logic [7:0]          fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic                bit_end;

  assign tx.tx_ready = ~fifo_full & ~rst;
  assign push        = tx.tx_valid & tx.tx_ready;
  assign bit_end     = (bit_cnt == CntWidth'(BitCycles - 1));
  assign busy        = (state != IDLE) || (fifo_count != '0);

  serial_tx_fifo #(
    .Width     (8),
    .DepthLog2 (FifoDepthLog2)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (tx.tx_data),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = START;
        end
      end
      START: begin
        if (bit_end) next_state = DATA;
      end
      DATA: begin
        if (bit_end && bit_idx == 3'd7) next_state = STOP;
      end
      STOP: begin
        // Chain straight into the next start bit when more bytes wait.
        if (bit_end) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            next_state = START;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // TxD is registered from the current state, so the line trails the FSM by one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      TxD     <= 1'b1;
    end else begin
      case (state)
        START:   TxD <= 1'b0;
        DATA:    TxD <= shift[0];
        default: TxD <= 1'b1;
      endcase
      if (pop) begin
        shift   <= fifo_head;
        bit_cnt <= '0;
        bit_idx <= '0;
      end else if (state != IDLE) begin
        if (bit_end) begin
          bit_cnt <= '0;
          if (state == DATA) begin
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_tx_buffered.sv
// Directed bench for serial_tx_buffered: fast-rate, shallow-FIFO and default-rate instances.
module tb_serial_tx_buffered;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  serial_tx_buffered_if if_a ();
  serial_tx_buffered_if if_b ();
  serial_tx_buffered_if if_c ();

  logic       txd_a, txd_b, txd_c;
  logic       busy_a, busy_b, busy_c;
  logic [4:0] count_a, count_c;
  logic [2:0] count_b;

  serial_tx_buffered #(.ClkFrequency(1600), .Baud(100), .FifoDepthLog2(4)) dut_a (
    .clk(clk), .rst(rst), .tx(if_a), .TxD(txd_a), .busy(busy_a), .fifo_count(count_a));

  serial_tx_buffered #(.ClkFrequency(1600), .Baud(100), .FifoDepthLog2(2)) dut_b (
    .clk(clk), .rst(rst), .tx(if_b), .TxD(txd_b), .busy(busy_b), .fifo_count(count_b));

  serial_tx_buffered #(.ClkFrequency(24000000), .Baud(115200), .FifoDepthLog2(4)) dut_c (
    .clk(clk), .rst(rst), .tx(if_c), .TxD(txd_c), .busy(busy_c), .fifo_count(count_c));

  int          sel;
  logic        line;
  logic        cur_busy;
  logic        cur_ready;
  logic [31:0] cur_count;

  always_comb begin
    line      = txd_a;
    cur_busy  = busy_a;
    cur_ready = if_a.tx_ready;
    cur_count = 32'(count_a);
    case (sel)
      1: begin
        line      = txd_b;
        cur_busy  = busy_b;
        cur_ready = if_b.tx_ready;
        cur_count = 32'(count_b);
      end
      2: begin
        line      = txd_c;
        cur_busy  = busy_c;
        cur_ready = if_c.tx_ready;
        cur_count = 32'(count_c);
      end
      default: ;
    endcase
  end

  // Independent receiver for the shallow-FIFO instance (16 clocks per bit).
  logic [7:0] mon_byte;
  logic [7:0] rx_b [$];

  always begin
    @(negedge txd_b);
    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      repeat (16) @(posedge clk);
      #1;
      mon_byte[i] = txd_b;
    end
    repeat (16) @(posedge clk);
    #1;
    rx_b.push_back(mon_byte);
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one byte to the selected instance for exactly one edge.
  task automatic apply_stimulus(input int which, input logic [7:0] d);
    check_output("ready_before_push", 32'(cur_ready), 32'd1);
    case (which)
      1:       begin if_b.tx_valid = 1'b1; if_b.tx_data = d; end
      2:       begin if_c.tx_valid = 1'b1; if_c.tx_data = d; end
      default: begin if_a.tx_valid = 1'b1; if_a.tx_data = d; end
    endcase
    @(posedge clk);
    #1;
    if_a.tx_valid = 1'b0;
    if_b.tx_valid = 1'b0;
    if_c.tx_valid = 1'b0;
  endtask

  // Called just after the accepting edge k; returns at cycle 0 of the start bit (edge k+2).
  task automatic check_latency(input string tag);
    check_output({tag, "_txd_k0"}, 32'(line), 32'd1);
    check_output({tag, "_count_k0"}, cur_count, 32'd1);
    check_output({tag, "_busy_k0"}, 32'(cur_busy), 32'd1);
    wait_cycles(1);
    check_output({tag, "_txd_k1"}, 32'(line), 32'd1);
    wait_cycles(1);
    check_output({tag, "_txd_k2"}, 32'(line), 32'd0);
  endtask

  // Reference UART: entered at cycle 0 of a start bit, leaves at cycle 10*bc.
  task automatic decode_frame(input int bc, input logic [7:0] exp, input string tag);
    logic [7:0] rx;
    wait_cycles(bc / 2);
    check_output({tag, "_start"}, 32'(line), 32'd0);
    wait_cycles(bc - bc / 2 - 1);
    check_output({tag, "_start_last"}, 32'(line), 32'd0);
    wait_cycles(1);
    check_output({tag, "_bit0_first"}, 32'(line), 32'(exp[0]));
    wait_cycles(bc / 2);
    rx[0] = line;
    for (int i = 1; i < 8; i++) begin
      wait_cycles(bc);
      rx[i] = line;
    end
    check_output({tag, "_data"}, 32'(rx), 32'(exp));
    wait_cycles(bc);
    check_output({tag, "_stop"}, 32'(line), 32'd1);
    wait_cycles(bc - bc / 2);
  endtask

  initial begin
    int   v;
    int   accepted;
    int   budget;
    logic seen_drop;

    if_a.tx_valid = 1'b0; if_a.tx_data = '0;
    if_b.tx_valid = 1'b0; if_b.tx_data = '0;
    if_c.tx_valid = 1'b0; if_c.tx_data = '0;
    sel = 0;
    rst = 1'b1;
    wait_cycles(3);

    check_output("rst_txd_a", 32'(txd_a), 32'd1);
    check_output("rst_txd_b", 32'(txd_b), 32'd1);
    check_output("rst_txd_c", 32'(txd_c), 32'd1);
    check_output("rst_busy_a", 32'(busy_a), 32'd0);
    check_output("rst_busy_b", 32'(busy_b), 32'd0);
    check_output("rst_count_a", 32'(count_a), 32'd0);
    check_output("rst_count_b", 32'(count_b), 32'd0);
    check_output("rst_count_c", 32'(count_c), 32'd0);
    check_output("rst_ready_a", 32'(if_a.tx_ready), 32'd0);
    check_output("rst_ready_b", 32'(if_b.tx_ready), 32'd0);

    rst = 1'b0;
    wait_cycles(1);
    check_output("ready_after_rst", 32'(if_a.tx_ready), 32'd1);
    wait_cycles(2);

    // Single byte 0x41 at 16 clocks per bit.
    apply_stimulus(0, 8'h41);
    check_latency("single");
    decode_frame(16, 8'h41, "single");
    check_output("single_busy_end", 32'(busy_a), 32'd0);
    check_output("single_txd_end", 32'(txd_a), 32'd1);

    // Burst of three on consecutive edges, frames must abut.
    if_a.tx_valid = 1'b1; if_a.tx_data = 8'h00;
    wait_cycles(1);
    check_output("burst_count_0", 32'(count_a), 32'd1);
    if_a.tx_data = 8'hFF;
    wait_cycles(1);
    check_output("burst_count_1", 32'(count_a), 32'd1);
    if_a.tx_data = 8'h55;
    wait_cycles(1);
    if_a.tx_valid = 1'b0;
    check_output("burst_count_peak", 32'(count_a), 32'd2);
    check_output("burst_start", 32'(txd_a), 32'd0);
    decode_frame(16, 8'h00, "burst0");
    check_output("burst_gap1", 32'(txd_a), 32'd0);
    decode_frame(16, 8'hFF, "burst1");
    check_output("burst_gap2", 32'(txd_a), 32'd0);
    decode_frame(16, 8'h55, "burst2");
    check_output("burst_busy_end", 32'(busy_a), 32'd0);
    check_output("burst_txd_end", 32'(txd_a), 32'd1);

    // Reset during data bit 3 of 0xA5 with two bytes queued behind it.
    apply_stimulus(0, 8'hA5);
    apply_stimulus(0, 8'h11);
    apply_stimulus(0, 8'h22);
    check_output("midrst_started", 32'(txd_a), 32'd0);
    wait_cycles(70);
    check_output("midrst_queued", 32'(count_a), 32'd2);
    check_output("midrst_bit3", 32'(txd_a), 32'd0);
    rst = 1'b1;
    wait_cycles(1);
    check_output("midrst_txd", 32'(txd_a), 32'd1);
    check_output("midrst_count", 32'(count_a), 32'd0);
    check_output("midrst_busy", 32'(busy_a), 32'd0);
    check_output("midrst_ready", 32'(if_a.tx_ready), 32'd0);
    rst = 1'b0;
    #1;
    check_output("midrst_ready_release", 32'(if_a.tx_ready), 32'd1);
    wait_cycles(20);
    check_output("midrst_quiet_txd", 32'(txd_a), 32'd1);
    check_output("midrst_quiet_busy", 32'(busy_a), 32'd0);
    apply_stimulus(0, 8'h3C);
    check_latency("after_rst");
    decode_frame(16, 8'h3C, "after_rst");

    // Four-deep FIFO held under pressure with bytes 1..8.
    sel = 1;
    v = 1;
    accepted = 0;
    budget = 0;
    seen_drop = 1'b0;
    if_b.tx_valid = 1'b1;
    if_b.tx_data  = 8'd1;
    while (v <= 8 && budget < 4000) begin
      if (!if_b.tx_ready && !seen_drop) begin
        seen_drop = 1'b1;
        check_output("full_count_at_drop", 32'(count_b), 32'd4);
        check_output("full_accepted_at_drop", 32'(accepted), 32'd5);
      end
      if (if_b.tx_ready) begin
        @(posedge clk);
        #1;
        accepted++;
        v++;
        if_b.tx_data = 8'(v);
      end else begin
        wait_cycles(1);
      end
      budget++;
    end
    if_b.tx_valid = 1'b0;
    check_output("full_saw_drop", 32'(seen_drop), 32'd1);
    check_output("full_all_accepted", 32'(accepted), 32'd8);
    budget = 0;
    while (rx_b.size() < 8 && budget < 3000) begin
      wait_cycles(1);
      budget++;
    end
    wait_cycles(200);
    check_output("full_rx_size", 32'(rx_b.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check_output("full_rx_order", (i < rx_b.size()) ? 32'(rx_b[i]) : 32'hxxxx_xxxx, 32'(i + 1));
    end
    check_output("full_busy_end", 32'(busy_b), 32'd0);

    // Default 24 MHz / 115200: 208 clocks per bit.
    sel = 2;
    apply_stimulus(2, 8'h7E);
    check_latency("default");
    decode_frame(208, 8'h7E, "default");
    check_output("default_busy_end", 32'(busy_c), 32'd0);
    check_output("default_txd_end", 32'(txd_c), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_tx_buffered.md
# serial_tx_buffered

Buffered 8N1 serial transmitter: accepts bytes from on-chip logic through a valid/ready handshake, queues them in a small FIFO, and shifts them out on `TxD` at a fixed baud rate. It is the transmit-direction counterpart to the serial receive path. It lets bursts of status or response bytes (for example LED/button state reports) go to the PC's serial port without the producer tracking line timing.

## Interface
- `ClkFrequency`, default 24000000: clock frequency in Hz; must match the board.
- `Baud`, default 115200: line rate in bit/s.
- `FifoDepthLog2`, default 4: FIFO depth is 2^FifoDepthLog2 bytes (16).
- `clk`, input, 1: system clock; all logic on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `tx_valid`, input, 1: producer offers `tx_data`.
- `tx_data`, input, 8: byte to send.
- `tx_ready`, output, 1: FIFO can accept a byte. A byte transfers on the edge where `tx_valid & tx_ready`.
- `TxD`, output, 1: serial line. Idle is high.
- `busy`, output, 1: high when a frame is in flight or the FIFO is non-empty.
- `fifo_count`, output, FifoDepthLog2+1: number of bytes queued, excluding the byte being shifted.

## Operation
- Bit period: BitCycles = (ClkFrequency + Baud/2) / Baud, integer, rounded to nearest. The default is 208.
  - Elaboration error if BitCycles < 2.
  - Every bit, including start and stop, lasts exactly BitCycles clocks.
- Frame format: start bit (0), then 8 data bits LSB first, then 1 stop bit (1). No parity. A frame is 10*BitCycles clocks.
- FIFO:
  - Synchronous, first-in first-out.
  - `tx_ready` = not full and not `rst`. A push is refused when full even if a pop happens in the same cycle.
  - Simultaneous push and pop leaves `fifo_count` unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `TxD`=1. If FIFO is non-empty: pop the head into the shift register, clear the bit-period counter, go to START.
  - START: `TxD`=0 for BitCycles clocks, then go to DATA with bit index 0.
  - DATA: `TxD` = shift[0] for BitCycles clocks, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: `TxD`=1 for BitCycles clocks. On the last stop cycle: if the FIFO is non-empty, pop and go directly to START (back-to-back, no idle gap); otherwise go to IDLE.
- `busy` = (state != IDLE) or (`fifo_count` != 0).
- Bytes written while a frame is in flight are queued. They never alter the frame in progress.

## Timing
- Reset values, applied at the edge where `rst`=1:
  - `TxD`=1, state=IDLE, FIFO empty, `fifo_count`=0, `busy`=0.
  - `tx_ready`=0 while `rst` is high; it becomes 1 in the first cycle after `rst` falls.
- Reset mid-frame: the frame is truncated. `TxD` is high after the reset edge and all queued bytes are discarded.
- `TxD` is a registered output, so there are no glitches.
- Latency: a byte accepted at edge k into an empty FIFO with the FSM in IDLE drives `TxD` low from edge k+2, after one cycle for the FIFO write and one for the pop.
- Back-to-back frames: the next start bit begins on the clock immediately after the last stop-bit clock.
- Sustained throughput is one byte per 10*BitCycles clocks.
- `fifo_count` reflects a push or pop on the edge after it occurs.

## Structure
- Shared package holds:
  - the state enum (IDLE/START/DATA/STOP);
  - a constant function computing BitCycles from ClkFrequency and Baud;
  - the frame-length constant (10 bits).
- Sub-module `serial_tx_fifo`: a synchronous FIFO parameterised by width (8) and FifoDepthLog2, with push/pop/full/empty/count. It is reusable for a buffered receive path later.
- The top holds the bit-period counter, the bit index, the shift register, and the FSM.

## Test plan
- Single byte: use ClkFrequency=1600, Baud=100 (BitCycles=16). Write 0x41 once.
  - `TxD` goes low 2 clocks after acceptance.
  - Bits sampled at mid-period read 0, 1,0,0,0,0,0,1,0, then 1.
  - Frame lasts 160 clocks, after which `busy` falls.
- Burst and back-to-back: write 0x00, 0xFF, 0x55 on consecutive cycles.
  - `fifo_count` peaks at 2.
  - The three frames are contiguous: 480 clocks from the first start edge to the end of the last stop bit, with no idle gap.
- Full FIFO: with FifoDepthLog2=2, hold `tx_valid` high with values 1..8 while the line is busy.
  - `tx_ready` drops when `fifo_count`=4.
  - No byte is lost or duplicated; the bytes are received in the order 1..8.
- Reset mid-frame: assert `rst` during data bit 3 of 0xA5 with 2 bytes queued.
  - Next edge: `TxD`=1, `fifo_count`=0, `busy`=0.
  - After release, a new 0x3C is sent intact.
- Default rate: ClkFrequency=24000000, Baud=115200.
  - Each bit lasts 208 clocks; a frame lasts 2080 clocks.
  - A reference UART model decodes 0x7E correctly.
